// File: rtl/rd_bank_router_pkg.sv
// ---------------------------------------------------------------------------
// mbfft_rd_pkg
//  Shared defaults and types for the FFT read-data stage (rd_bank_router).
//  DEF_* constants are the default configuration; RW and PW are the rotation
//  and FIFO pointer widths for that default configuration. Modules that take
//  these as parameters recompute their own widths locally.
// ---------------------------------------------------------------------------
package mbfft_rd_pkg;

  localparam int DEF_DATA_W     = 32;
  localparam int DEF_NUM_BANKS  = 2;
  localparam int DEF_FIFO_DEPTH = 4;

  localparam int RW = $clog2(DEF_NUM_BANKS);
  localparam int PW = $clog2(DEF_FIFO_DEPTH);

  // One complex sample: real in the upper half, imag in the lower half.
  typedef logic [DEF_DATA_W-1:0] lane_t;

endpackage

// File: rtl/rd_bank_router_if.sv
// ---------------------------------------------------------------------------
// rd_bank_router_if
//  Lane-vector output stream of rd_bank_router.
//  Signals:
//    out_valid_o  router -> consumer  out_data_o holds a valid lane vector
//    out_ready_i  consumer -> router  consumer accepts the vector
//    out_data_o   router -> consumer  lane k at [k*DATA_W +: DATA_W]
//  Handshake: a vector transfers on a cycle where out_valid_o and out_ready_i
//  are both 1. While out_valid_o=1 and out_ready_i=0, out_valid_o and
//  out_data_o stay unchanged. out_valid_o never depends on out_ready_i.
//  Modports: master = router side, slave = consumer side.
// ---------------------------------------------------------------------------
interface rd_bank_router_if
  import mbfft_rd_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int NUM_BANKS = DEF_NUM_BANKS
) ();

  logic                          out_valid_o;
  logic                          out_ready_i;
  logic [NUM_BANKS*DATA_W-1:0]   out_data_o;

  modport master (
    output out_valid_o,
    output out_data_o,
    input  out_ready_i
  );

  modport slave (
    input  out_valid_o,
    input  out_data_o,
    output out_ready_i
  );

endinterface

// File: rtl/rd_bank_router_sync_fifo.sv
// ---------------------------------------------------------------------------
// rd_sync_fifo
//  Registered-storage synchronous FIFO with a first-word-fall-through head.
//  Ports:
//    clk, rstn   clock, async active-low reset
//    flush_i     sync clear of pointers and count (wins over push/pop)
//    push_i      write din_i (ignored when full and not popping)
//    din_i       write data
//    pop_i       remove head (ignored when empty)
//    dout_o      head entry, forced to 0 while empty
//    valid_o     FIFO holds at least one entry
//    count_o     number of stored entries
//  DEPTH must be a power of 2 so the pointers wrap naturally.
// ---------------------------------------------------------------------------
module rd_sync_fifo
  import mbfft_rd_pkg::*;
#(
  parameter int W     = 64,
  parameter int DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  logic [W-1:0]               din_i,
  input  logic                       pop_i,
  output logic [W-1:0]               dout_o,
  output logic                       valid_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             do_push, do_pop;

  assign do_pop  = pop_i && (count_q != '0);
  // A pop frees a slot in the same cycle, so a full FIFO may still take a push.
  assign do_push = push_i && ((count_q != (PTR_W+1)'(DEPTH)) || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + (PTR_W+1)'(1);
        2'b01:   count_d = count_q - (PTR_W+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: nothing reads it until the count says it is filled.
  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= din_i;
  end

  assign valid_o = (count_q != '0);
  assign dout_o  = valid_o ? mem_q[rd_ptr_q] : '0;
  assign count_o = count_q;

endmodule

// File: rtl/rd_bank_router.sv
// ---------------------------------------------------------------------------
// rd_bank_router
//  Read-data stage of the memory-based FFT. Bank outputs arriving RD_LAT
//  cycles after a read is issued are rotated into butterfly lanes using the
//  rotation captured at issue time, then buffered in a credit-protected
//  FIFO so the butterfly can stall.
//  Ports:
//    clk, rstn     clock, async active-low reset
//    rd_req_i      read issued to all banks this cycle
//    rot_i         lane rotation for this request
//    conj_i        conjugate request (present only with RD_CONJ_EN)
//    flush_i       sync flush of in-flight reads and buffered vectors
//    data_bank_i   bank b at [b*DATA_W +: DATA_W]
//    credit_ok_o   upstream may issue a read this cycle
//    overflow_o    sticky: a read was issued without credit
//    out_if        lane-vector output stream (master side)
//  Build option: define RD_CONJ_EN to add conj_i and the conjugate path
//  (imag half negated, most negative value saturates to most positive).
// ---------------------------------------------------------------------------
module rd_bank_router
  import mbfft_rd_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int NUM_BANKS  = DEF_NUM_BANKS,
  parameter int RD_LAT     = 1,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          rd_req_i,
  input  logic [$clog2(NUM_BANKS)-1:0]  rot_i,
`ifdef RD_CONJ_EN
  input  logic                          conj_i,
`endif
  input  logic                          flush_i,
  input  logic [NUM_BANKS*DATA_W-1:0]   data_bank_i,
  output logic                          credit_ok_o,
  output logic                          overflow_o,
  rd_bank_router_if.master              out_if
);

  localparam int ROT_W  = $clog2(NUM_BANKS);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  // Wide enough for fifo count plus every tag stage.
  localparam int CNT_W  = PTR_W + 2;
  localparam int HALF_W = DATA_W / 2;
  localparam int VEC_W  = NUM_BANKS * DATA_W;

  // ---------------- tag pipe ----------------
  logic [RD_LAT-1:0] vld_q;
  logic [ROT_W-1:0]  rot_q [RD_LAT];
  logic              tag_vld_d;

  // Flush discards any request issued in the same cycle.
  assign tag_vld_d = rd_req_i && credit_ok_o && !flush_i;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vld_q <= '0;
      for (int s = 0; s < RD_LAT; s++) rot_q[s] <= '0;
    end else if (flush_i) begin
      vld_q <= '0;
    end else begin
      vld_q[0] <= tag_vld_d;
      rot_q[0] <= rot_i;
      for (int s = 1; s < RD_LAT; s++) begin
        vld_q[s] <= vld_q[s-1];
        rot_q[s] <= rot_q[s-1];
      end
    end
  end

`ifdef RD_CONJ_EN
  logic [RD_LAT-1:0] conj_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      conj_q <= '0;
    end else if (!flush_i) begin
      conj_q[0] <= conj_i;
      for (int s = 1; s < RD_LAT; s++) conj_q[s] <= conj_q[s-1];
    end
  end

  // Negate imag; -(most negative) is not representable, so clamp it.
  function automatic logic [DATA_W-1:0] conj_lane(input logic [DATA_W-1:0] x);
    logic [HALF_W-1:0] im;
    logic [HALF_W-1:0] neg;
    im = x[HALF_W-1:0];
    if (im == {1'b1, {(HALF_W-1){1'b0}}}) neg = {1'b0, {(HALF_W-1){1'b1}}};
    else                                  neg = -im;
    return {x[DATA_W-1:HALF_W], neg};
  endfunction
`endif

  // ---------------- rotator ----------------
  logic [ROT_W-1:0]  rot_last;
  logic [ROT_W-1:0]  src_idx;
  logic [DATA_W-1:0] lane;
  logic [VEC_W-1:0]  lanes;

  assign rot_last = rot_q[RD_LAT-1];

  // lane k = bank[(k + rot) mod NUM_BANKS]; the mod is free at ROT_W bits.
  always_comb begin
    src_idx = '0;
    lane    = '0;
    lanes   = '0;
    for (int k = 0; k < NUM_BANKS; k++) begin
      src_idx = ROT_W'(k) + rot_last;
      lane    = data_bank_i[src_idx*DATA_W +: DATA_W];
`ifdef RD_CONJ_EN
      if (conj_q[RD_LAT-1]) lane = conj_lane(lane);
`endif
      lanes[k*DATA_W +: DATA_W] = lane;
    end
  end

  // ---------------- FIFO ----------------
  logic [PTR_W:0] fifo_cnt;

  rd_sync_fifo #(
    .W     (VEC_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .flush_i (flush_i),
    .push_i  (vld_q[RD_LAT-1]),
    .din_i   (lanes),
    .pop_i   (out_if.out_ready_i),
    .dout_o  (out_if.out_data_o),
    .valid_o (out_if.out_valid_o),
    .count_o (fifo_cnt)
  );

  // ---------------- credit ----------------
  // Every valid tag stage owns a FIFO slot, so the sum never exceeds the depth.
  // Pops only show up through fifo_cnt one cycle later.
  logic [CNT_W-1:0] inflight;

  always_comb begin
    inflight = '0;
    for (int s = 0; s < RD_LAT; s++) inflight = inflight + CNT_W'(vld_q[s]);
  end

  assign credit_ok_o = (inflight + CNT_W'(fifo_cnt)) < CNT_W'(FIFO_DEPTH);

  // ---------------- overflow ----------------
  logic ovf_q, ovf_d;

  assign ovf_d = ovf_q || (rd_req_i && !credit_ok_o && !flush_i);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) ovf_q <= 1'b0;
    else       ovf_q <= ovf_d;
  end

  assign overflow_o = ovf_q;

endmodule

// File: tb/tb_rd_bank_router.sv
module tb_rd_bank_router;
  import mbfft_rd_pkg::*;

  localparam int DW    = 32;
  localparam int NB    = 2;
  localparam int LAT   = 1;
  localparam int DEPTH = 4;
  localparam int VW    = NB * DW;

  // ---------------- clock / reset ----------------
  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT (2 banks) ----------------
  logic           rd_req, flush, conj, ready;
  logic [0:0]     rot;
  logic [VW-1:0]  bank;
  logic           credit, ovf;

  rd_bank_router_if #(.DATA_W(DW), .NUM_BANKS(NB)) oif ();
  assign oif.out_ready_i = ready;

  rd_bank_router #(.DATA_W(DW), .NUM_BANKS(NB), .RD_LAT(LAT), .FIFO_DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .rd_req_i    (rd_req),
    .rot_i       (rot),
`ifdef RD_CONJ_EN
    .conj_i      (conj),
`endif
    .flush_i     (flush),
    .data_bank_i (bank),
    .credit_ok_o (credit),
    .overflow_o  (ovf),
    .out_if      (oif)
  );

  // ---------------- DUT (4 banks) ----------------
  logic         rd_req4;
  logic [1:0]   rot4;
  logic [127:0] bank4;
  logic         credit4, ovf4;

  rd_bank_router_if #(.DATA_W(DW), .NUM_BANKS(4)) oif4 ();
  assign oif4.out_ready_i = 1'b1;

  rd_bank_router #(.DATA_W(DW), .NUM_BANKS(4), .RD_LAT(1), .FIFO_DEPTH(4)) u4 (
    .clk         (clk),
    .rstn        (rstn),
    .rd_req_i    (rd_req4),
    .rot_i       (rot4),
`ifdef RD_CONJ_EN
    .conj_i      (1'b0),
`endif
    .flush_i     (1'b0),
    .data_bank_i (bank4),
    .credit_ok_o (credit4),
    .overflow_o  (ovf4),
    .out_if      (oif4)
  );

  // ---------------- reference model / scoreboard ----------------
  logic [VW-1:0] exp_q[$];
  int            pend_due[$];
  int            pend_rot[$];
  bit            pend_conj[$];
  bit            m_ovf;
  int            cyc;
  int            errors;
  int            checks;
  int            hs_cnt;

  function automatic logic [VW-1:0] model_vec(logic [VW-1:0] b, int r, bit cj);
    logic [VW-1:0] v;
    lane_t         x;
    logic [15:0]   im;
    v = '0;
    for (int k = 0; k < NB; k++) begin
      x = b[((k + r) % NB)*DW +: DW];
      if (cj) begin
        im = x[15:0];
        if (im == 16'h8000) im = 16'h7FFF;
        else                im = 16'h0000 - im;
        x[15:0] = im;
      end
      v[k*DW +: DW] = x;
    end
    return v;
  endfunction

  task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    pend_due.delete();
    pend_rot.delete();
    pend_conj.delete();
    m_ovf = 1'b0;
  endtask

  // Compare outputs for the current cycle, then advance one clock and model it.
  task automatic step();
    bit            credit_m, pop_m, push_m, acc_m;
    logic [VW-1:0] vec;
    credit_m = (pend_due.size() + exp_q.size()) < DEPTH;
    chk("credit_ok", credit, credit_m);
    chk("out_valid", oif.out_valid_o, exp_q.size() != 0);
    if (exp_q.size() != 0) chk("out_data", oif.out_data_o, exp_q[0]);
    chk("overflow", ovf, m_ovf);
    pop_m  = ready && (exp_q.size() != 0);
    push_m = (pend_due.size() != 0) && (pend_due[0] == cyc);
    vec    = push_m ? model_vec(bank, pend_rot[0], pend_conj[0]) : '0;
    acc_m  = rd_req && credit_m && !flush;
    if (rd_req && !credit_m && !flush) m_ovf = 1'b1;
    if (oif.out_valid_o && ready) hs_cnt++;
    @(posedge clk);
    #1;
    if (flush) begin
      exp_q.delete();
      pend_due.delete();
      pend_rot.delete();
      pend_conj.delete();
    end else begin
      if (pop_m) void'(exp_q.pop_front());
      if (push_m) begin
        void'(pend_due.pop_front());
        void'(pend_rot.pop_front());
        void'(pend_conj.pop_front());
        exp_q.push_back(vec);
      end
      if (acc_m) begin
        pend_due.push_back(cyc + LAT);
        pend_rot.push_back(int'(rot));
        pend_conj.push_back(conj);
      end
    end
    cyc++;
  endtask

  task automatic chk_reset_values(string tag);
    chk({tag, "_credit"},   credit,          1'b1);
    chk({tag, "_valid"},    oif.out_valid_o, 1'b0);
    chk({tag, "_data"},     oif.out_data_o,  '0);
    chk({tag, "_overflow"}, ovf,             1'b0);
    chk({tag, "_valid4"},   oif4.out_valid_o, 1'b0);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        rot;
    logic [31:0] b0;
    logic [31:0] b1;
    logic [31:0] l0;
    logic [31:0] l1;
  } vec_t;

  vec_t tbl[4];

  // ---------------- test sequence ----------------
  initial begin
    errors = 0; checks = 0; cyc = 0; hs_cnt = 0;
    rd_req = 0; rot = '0; flush = 0; conj = 0; ready = 0; bank = '0;
    rd_req4 = 0; rot4 = '0; bank4 = '0;
    model_clear();

    tbl[0] = '{rot: 1'b0, b0: 32'h0003_0004, b1: 32'h0001_0002, l0: 32'h0003_0004, l1: 32'h0001_0002};
    tbl[1] = '{rot: 1'b1, b0: 32'h0003_0004, b1: 32'h0001_0002, l0: 32'h0001_0002, l1: 32'h0003_0004};
    tbl[2] = '{rot: 1'b1, b0: 32'hDEAD_BEEF, b1: 32'h1234_5678, l0: 32'h1234_5678, l1: 32'hDEAD_BEEF};
    tbl[3] = '{rot: 1'b0, b0: 32'hFFFF_0000, b1: 32'h0000_FFFF, l0: 32'hFFFF_0000, l1: 32'h0000_FFFF};

    // Reset state
    #12;
    chk_reset_values("reset");
    @(posedge clk);
    #1;
    rstn = 1'b1;

    // Single requests: valid two cycles after issue with the rotated lanes
    ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rd_req = 1'b1;
      rot    = tbl[i].rot;
      step();
      rd_req = 1'b0;
      bank   = {tbl[i].b1, tbl[i].b0};
      chk("tv_early_valid", oif.out_valid_o, 1'b0);
      step();
      bank = {$urandom, $urandom};
      chk("tv_valid", oif.out_valid_o, 1'b1);
      chk("tv_lane0", oif.out_data_o[31:0],  tbl[i].l0);
      chk("tv_lane1", oif.out_data_o[63:32], tbl[i].l1);
      step();
    end

    // Four banks, rot=3, banks b_i=i
    rd_req4 = 1'b1;
    rot4    = 2'd3;
    step();
    rd_req4 = 1'b0;
    bank4   = {32'd3, 32'd2, 32'd1, 32'd0};
    step();
    chk("nb4_valid", oif4.out_valid_o, 1'b1);
    chk("nb4_lanes", oif4.out_data_o, {32'd2, 32'd1, 32'd0, 32'd3});
    step();

    // Stalled consumer with a request every cycle: credit caps at depth
    ready  = 1'b0;
    rd_req = 1'b1;
    for (int i = 0; i < 8; i++) begin
      rot  = 1'($urandom_range(0, 1));
      bank = {$urandom, $urandom};
      step();
    end
    chk("stall_credit", credit, 1'b0);
    chk("stall_overflow", ovf, 1'b1);
    rd_req = 1'b0;
    ready  = 1'b1;
    hs_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      bank = {$urandom, $urandom};
      step();
    end
    chk("drain_count", hs_cnt, 4);
    chk("drain_credit", credit, 1'b1);
    chk("overflow_sticky", ovf, 1'b1);

    // Flush with 2 buffered and 1 in flight; request in the flush cycle is dropped
    ready  = 1'b0;
    rd_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rot  = 1'($urandom_range(0, 1));
      bank = {$urandom, $urandom};
      step();
    end
    flush = 1'b1;
    bank  = {$urandom, $urandom};
    step();
    flush  = 1'b0;
    rd_req = 1'b0;
    chk("flush_valid", oif.out_valid_o, 1'b0);
    chk("flush_credit", credit, 1'b1);
    chk("flush_overflow", ovf, 1'b1);
    for (int i = 0; i < 3; i++) begin
      bank = {$urandom, $urandom};
      step();
    end
    chk("flush_no_late_push", oif.out_valid_o, 1'b0);

`ifdef RD_CONJ_EN
    // Conjugate with saturation of the most negative imag value
    ready  = 1'b1;
    rd_req = 1'b1;
    conj   = 1'b1;
    rot    = 1'b0;
    step();
    rd_req = 1'b0;
    conj   = 1'b0;
    bank   = {32'h0005_8000, 32'h0005_8000};
    step();
    chk("conj_lane0", oif.out_data_o[31:0], 32'h0005_7FFF);
    step();
`endif

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      rd_req = ($urandom_range(0, 3) != 0);
      rot    = 1'($urandom_range(0, 1));
      ready  = ($urandom_range(0, 9) < 6);
      flush  = ($urandom_range(0, 39) == 0);
      bank   = {$urandom, $urandom};
`ifdef RD_CONJ_EN
      conj   = 1'($urandom_range(0, 1));
`endif
      step();
    end
    flush = 1'b0;
    conj  = 1'b0;

    // Reset mid-burst: outputs return to reset values without a clock edge
    ready  = 1'b0;
    rd_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bank = {$urandom, $urandom};
      step();
    end
    #3;
    rstn = 1'b0;
    #1;
    chk_reset_values("async_reset");
    rd_req = 1'b0;
    @(posedge clk);
    #1;
    rstn = 1'b1;
    cyc++;
    model_clear();
    ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bank = {$urandom, $urandom};
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
